// File: rtl/regfile_access_ctrl_if.sv
// Debug request/response channel into the regfile access controller.
// Request is a valid/ready handshake; the response is an unthrottled one-cycle pulse.
interface regfile_access_ctrl_if;
    logic        dbg_req_valid;
    logic        dbg_req_we;
    logic [4:0]  dbg_req_addr;
    logic [31:0] dbg_req_wdata;
    logic        dbg_req_ready;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_rdata;

    modport master (
        output dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
        input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata
    );

    modport slave (
        input  dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
        output dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Zeroes x1..x31 after reset, then muxes core and single-outstanding debug traffic onto the regfile.
// Debug read: response 2 cycles after accept; debug write waits for a free port, stealing it after MAX_WAIT busy cycles.
module regfile_access_ctrl #(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter int unsigned MAX_WAIT       = 15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        core_write,
    input  logic [4:0]  core_wa,
    input  logic [31:0] core_wd,
    input  logic [4:0]  core_ra1,
    input  logic [4:0]  core_ra2,
    output logic [31:0] core_rd1,
    output logic [31:0] core_rd2,
    output logic        core_stall,

    output logic        rf_write,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [4:0]  rf_ra1,
    output logic [4:0]  rf_ra2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,

    regfile_access_ctrl_if.slave dbg
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WR,
        S_RD,
        S_RSP
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t              state_q, state_d;
    logic [4:0]          clr_cnt_q, clr_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                req_we_q, req_we_d;
    logic [4:0]          req_addr_q, req_addr_d;
    logic [31:0]         req_wdata_q, req_wdata_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;

    assign core_rd1 = rf_rd1;
    assign core_rd2 = rf_rd2;
    assign dbg.dbg_rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_STATE;
            clr_cnt_q   <= 5'd1;
            wait_cnt_q  <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= 5'd0;
            req_wdata_q <= 32'd0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rsp_rdata_d = rsp_rdata_q;

        rf_write    = core_write;
        rf_wa       = core_wa;
        rf_wd       = core_wd;
        rf_ra1      = core_ra1;
        rf_ra2      = core_ra2;
        core_stall  = 1'b0;

        dbg.dbg_req_ready = 1'b0;
        dbg.dbg_rsp_valid = 1'b0;

        unique case (state_q)
            S_CLEAR: begin
                rf_write   = 1'b1;
                rf_wa      = clr_cnt_q;
                rf_wd      = 32'd0;
                core_stall = 1'b1;
                if (clr_cnt_q == 5'd31) begin
                    clr_cnt_d = 5'd1;
                    state_d   = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 5'd1;
                end
            end

            S_IDLE: begin
                dbg.dbg_req_ready = 1'b1;
                if (dbg.dbg_req_valid) begin
                    req_we_d    = dbg.dbg_req_we;
                    req_addr_d  = dbg.dbg_req_addr;
                    req_wdata_d = dbg.dbg_req_wdata;
                    wait_cnt_d  = '0;
                    state_d     = dbg.dbg_req_we ? S_WR : S_RD;
                end
            end

            S_WR: begin
                // The write is issued in the reset cycle only if reset is low,
                // so an aborted request never reaches the regfile.
                if (!core_write || wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
                    core_stall = core_write;
                    if (!rst) begin
                        rf_write = 1'b1;
                        rf_wa    = req_addr_q;
                        rf_wd    = req_wdata_q;
                    end else begin
                        rf_write = 1'b0;
                    end
                    rsp_rdata_d = 32'd0;
                    state_d     = S_RSP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_RD: begin
                core_stall  = 1'b1;
                rf_write    = 1'b0;
                rf_ra2      = req_addr_q;
                rsp_rdata_d = (req_addr_q == 5'd0) ? 32'd0 : rf_rd2;
                state_d     = S_RSP;
            end

            S_RSP: begin
                dbg.dbg_rsp_valid = !rst;
                state_d           = S_IDLE;
            end

            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural regfile behind it.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_write;
    logic [4:0]  core_wa, core_ra1, core_ra2;
    logic [31:0] core_wd;
    logic [31:0] core_rd1, core_rd2;
    logic        core_stall;
    logic        rf_write;
    logic [4:0]  rf_wa, rf_ra1, rf_ra2;
    logic [31:0] rf_wd, rf_rd1, rf_rd2;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [32] = '{default: 32'd0};

    regfile_access_ctrl_if dbg ();

    regfile_access_ctrl #(.CLEAR_ON_RESET(1'b1), .MAX_WAIT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_write (core_write),
        .core_wa    (core_wa),
        .core_wd    (core_wd),
        .core_ra1   (core_ra1),
        .core_ra2   (core_ra2),
        .core_rd1   (core_rd1),
        .core_rd2   (core_rd2),
        .core_stall (core_stall),
        .rf_write   (rf_write),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .rf_ra1     (rf_ra1),
        .rf_ra2     (rf_ra2),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .dbg        (dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_write && rf_wa != 5'd0) mem[rf_wa] <= rf_wd;
    end

    assign rf_rd1 = (rf_ra1 == 5'd0) ? 32'd0 : mem[rf_ra1];
    assign rf_rd2 = (rf_ra2 == 5'd0) ? 32'd0 : mem[rf_ra2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_clear_check(input string nm);
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            tests++;
            if (core_stall !== 1'b1 || rf_write !== 1'b1 || rf_wa !== 5'(i) ||
                rf_wd !== 32'd0 || dbg.dbg_rsp_valid !== 1'b0 || dbg.dbg_req_ready !== 1'b0) begin
                fails++;
                $display("FAIL %s clear cycle %0d: stall=%b wr=%b wa=%0d wd=%h rsp=%b rdy=%b, want 1 1 %0d 0 0 0",
                         nm, i, core_stall, rf_write, rf_wa, rf_wd, dbg.dbg_rsp_valid, dbg.dbg_req_ready, i);
            end
            step();
        end
        @(negedge clk);
        tests++;
        if (core_stall !== 1'b0 || dbg.dbg_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s after clear: stall=%b rdy=%b, want 0 1", nm, core_stall, dbg.dbg_req_ready);
        end
        step();
    endtask

    task automatic dbg_read(input logic [4:0] a, input logic [31:0] exp, input string nm);
        dbg.dbg_req_valid = 1'b1;
        dbg.dbg_req_we    = 1'b0;
        dbg.dbg_req_addr  = a;
        dbg.dbg_req_wdata = 32'd0;
        @(negedge clk);
        tests++;
        if (dbg.dbg_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: ready=%b want 1", nm, dbg.dbg_req_ready);
        end
        step();
        dbg.dbg_req_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (core_stall !== 1'b1 || rf_ra2 !== a || rf_write !== 1'b0 || dbg.dbg_rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s rd cycle: stall=%b ra2=%0d wr=%b rsp=%b, want 1 %0d 0 0",
                     nm, core_stall, rf_ra2, rf_write, dbg.dbg_rsp_valid, a);
        end
        step();
        @(negedge clk);
        tests++;
        if (dbg.dbg_rsp_valid !== 1'b1 || dbg.dbg_rsp_rdata !== exp || core_stall !== 1'b0) begin
            fails++;
            $display("FAIL %s rsp: valid=%b rdata=%h stall=%b, want 1 %h 0",
                     nm, dbg.dbg_rsp_valid, dbg.dbg_rsp_rdata, core_stall, exp);
        end
        step();
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [31:0] d, input string nm);
        dbg.dbg_req_valid = 1'b1;
        dbg.dbg_req_we    = 1'b1;
        dbg.dbg_req_addr  = a;
        dbg.dbg_req_wdata = d;
        @(negedge clk);
        tests++;
        if (dbg.dbg_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: ready=%b want 1", nm, dbg.dbg_req_ready);
        end
        step();
        dbg.dbg_req_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (rf_write !== 1'b1 || rf_wa !== a || rf_wd !== d || core_stall !== 1'b0 ||
            dbg.dbg_rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s wr cycle: wr=%b wa=%0d wd=%h stall=%b rsp=%b, want 1 %0d %h 0 0",
                     nm, rf_write, rf_wa, rf_wd, core_stall, dbg.dbg_rsp_valid, a, d);
        end
        step();
        @(negedge clk);
        tests++;
        if (dbg.dbg_rsp_valid !== 1'b1 || dbg.dbg_rsp_rdata !== 32'd0) begin
            fails++;
            $display("FAIL %s rsp: valid=%b rdata=%h, want 1 00000000",
                     nm, dbg.dbg_rsp_valid, dbg.dbg_rsp_rdata);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        @(negedge clk);
        tests++;
        if (core_stall !== 1'b1 || dbg.dbg_req_ready !== 1'b0 ||
            dbg.dbg_rsp_valid !== 1'b0 || dbg.dbg_rsp_rdata !== 32'd0) begin
            fails++;
            $display("FAIL reset_values: stall=%b rdy=%b rsp=%b rdata=%h, want 1 0 0 00000000",
                     core_stall, dbg.dbg_req_ready, dbg.dbg_rsp_valid, dbg.dbg_rsp_rdata);
        end
        step();
        rst = 1'b0;
        run_clear_check("reset_first");
    endtask

    task automatic test_reset_clear();
        for (int a = 1; a <= 31; a++) begin
            core_write = 1'b1;
            core_wa    = 5'(a);
            core_wd    = 32'hA5A5A5A5;
            step();
        end
        tests++;
        if (mem[17] !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL preload x17: got %h want a5a5a5a5", mem[17]);
        end
        core_write = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_clear_check("reset_clear");
        dbg_read(5'd1,  32'd0, "clear_rd_x1");
        dbg_read(5'd17, 32'd0, "clear_rd_x17");
        dbg_read(5'd31, 32'd0, "clear_rd_x31");
    endtask

    task automatic test_debug_read();
        core_write = 1'b1;
        core_wa    = 5'd5;
        core_wd    = 32'h12345678;
        @(negedge clk);
        tests++;
        if (core_stall !== 1'b0 || rf_write !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'h12345678) begin
            fails++;
            $display("FAIL core_passthrough: stall=%b wr=%b wa=%0d wd=%h, want 0 1 5 12345678",
                     core_stall, rf_write, rf_wa, rf_wd);
        end
        step();
        core_write = 1'b0;
        dbg_read(5'd5, 32'h12345678, "debug_read_x5");
        @(negedge clk);
        tests++;
        if (dbg.dbg_rsp_valid !== 1'b0 || dbg.dbg_rsp_rdata !== 32'h12345678) begin
            fails++;
            $display("FAIL rdata_hold: valid=%b rdata=%h, want 0 12345678",
                     dbg.dbg_rsp_valid, dbg.dbg_rsp_rdata);
        end
        step();
    endtask

    task automatic test_back_to_back();
        core_write = 1'b0;
        dbg_write(5'd9, 32'hDEADBEEF, "debug_write_x9");
        dbg_read(5'd9, 32'hDEADBEEF, "read_after_write_x9");
    endtask

    task automatic test_steal();
        core_write = 1'b1;
        core_wa    = 5'd20;
        core_wd    = 32'h11111111;
        dbg.dbg_req_valid = 1'b1;
        dbg.dbg_req_we    = 1'b1;
        dbg.dbg_req_addr  = 5'd3;
        dbg.dbg_req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        tests++;
        if (dbg.dbg_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL steal accept: ready=%b want 1", dbg.dbg_req_ready);
        end
        step();
        dbg.dbg_req_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            tests++;
            if (k < 16) begin
                if (core_stall !== 1'b0 || rf_write !== 1'b1 || rf_wa !== 5'd20 || rf_wd !== 32'h11111111) begin
                    fails++;
                    $display("FAIL steal wait cycle %0d: stall=%b wr=%b wa=%0d wd=%h, want 0 1 20 11111111",
                             k, core_stall, rf_write, rf_wa, rf_wd);
                end
            end else begin
                if (core_stall !== 1'b1 || rf_write !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'hCAFEF00D) begin
                    fails++;
                    $display("FAIL steal cycle 16: stall=%b wr=%b wa=%0d wd=%h, want 1 1 3 cafef00d",
                             core_stall, rf_write, rf_wa, rf_wd);
                end
            end
            step();
        end
        @(negedge clk);
        tests++;
        if (dbg.dbg_rsp_valid !== 1'b1 || core_stall !== 1'b0 || dbg.dbg_rsp_rdata !== 32'd0) begin
            fails++;
            $display("FAIL steal rsp: valid=%b stall=%b rdata=%h, want 1 0 00000000",
                     dbg.dbg_rsp_valid, core_stall, dbg.dbg_rsp_rdata);
        end
        core_write = 1'b0;
        step();
        dbg_read(5'd3, 32'hCAFEF00D, "steal_rd_x3");
    endtask

    task automatic test_x0();
        core_write = 1'b0;
        dbg_write(5'd0, 32'hFFFFFFFF, "x0_write");
        dbg_read(5'd0, 32'd0, "x0_read");
    endtask

    task automatic test_reset_mid();
        core_write = 1'b1;
        core_wa    = 5'd7;
        core_wd    = 32'h77777777;
        step();
        core_wa = 5'd20;
        core_wd = 32'h22222222;
        dbg.dbg_req_valid = 1'b1;
        dbg.dbg_req_we    = 1'b1;
        dbg.dbg_req_addr  = 5'd7;
        dbg.dbg_req_wdata = 32'h00000001;
        @(negedge clk);
        tests++;
        if (dbg.dbg_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid accept: ready=%b want 1", dbg.dbg_req_ready);
        end
        step();
        dbg.dbg_req_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (core_stall !== 1'b0 || rf_wa !== 5'd20) begin
            fails++;
            $display("FAIL rst_mid waiting: stall=%b wa=%0d, want 0 20", core_stall, rf_wa);
        end
        step();
        rst        = 1'b1;
        core_write = 1'b0;
        @(negedge clk);
        tests++;
        if (rf_write !== 1'b0 || dbg.dbg_rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid abort: wr=%b wa=%0d rsp=%b, want 0 - 0", rf_write, rf_wa, dbg.dbg_rsp_valid);
        end
        step();
        rst = 1'b0;
        tests++;
        if (mem[7] !== 32'h77777777) begin
            fails++;
            $display("FAIL rst_mid x7: got %h want 77777777", mem[7]);
        end
        run_clear_check("rst_mid");
    endtask

    initial begin
        rst               = 1'b1;
        core_write        = 1'b0;
        core_wa           = 5'd0;
        core_wd           = 32'd0;
        core_ra1          = 5'd1;
        core_ra2          = 5'd2;
        dbg.dbg_req_valid = 1'b0;
        dbg.dbg_req_we    = 1'b0;
        dbg.dbg_req_addr  = 5'd0;
        dbg.dbg_req_wdata = 32'd0;

        test_reset();
        test_reset_clear();
        test_debug_read();
        test_back_to_back();
        test_steal();
        test_x0();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Sequencer and arbiter in front of the rv32i register file. After reset it zeroes x1..x31 by sequencing the regfile write port. It then passes core traffic through and shares the regfile ports with a single-outstanding debug request channel. It sits between the single-cycle core's decode/writeback logic and `regfile`, which has combinational read and a write on the clock edge.

## Interface
- `CLEAR_ON_RESET`, default 1: 1 = run the x1..x31 zero sequence after reset; 0 = go straight to IDLE.
- `MAX_WAIT`, default 15, range ≥1: number of cycles a pending debug write waits for a free write port before it forces a one-cycle core stall.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `core_write`, `core_wa[4:0]`, `core_wd[31:0]`  in  1/5/32  core writeback request.
- `core_ra1[4:0]`, `core_ra2[4:0]`  in  5/5  core read addresses.
- `core_rd1[31:0]`, `core_rd2[31:0]`  out  32/32  read data to the core, wired directly from `rf_rd1`/`rf_rd2`.
- `core_stall`  out  1  core must not commit (no PC advance, no writeback) in this cycle.
- `rf_write`, `rf_wa[4:0]`, `rf_wd[31:0]`, `rf_ra1[4:0]`, `rf_ra2[4:0]`  out  regfile controls.
- `rf_rd1[31:0]`, `rf_rd2[31:0]`  in  32/32  regfile read data.
- `dbg_req_valid`, `dbg_req_we`, `dbg_req_addr[4:0]`, `dbg_req_wdata[31:0]`  in  debug request.
- `dbg_req_ready`  out  1  request accepted when `valid && ready` at the edge.
- `dbg_rsp_valid`  out  1  one-cycle response pulse.
- `dbg_rsp_rdata[31:0]`  out  32  read data; 0 for writes.

## Operation
- **States:** CLEAR, IDLE, WR, RD, RSP.
- **Default passthrough** (IDLE, RSP, and WR when not writing debug data):
  - `rf_write/wa/wd = core_write/wa/wd`
  - `rf_ra1 = core_ra1`, `rf_ra2 = core_ra2`
  - `core_stall = 0`
- **CLEAR:**
  - 5-bit `clr_cnt` starts at 1.
  - Each cycle drives `rf_write=1`, `rf_wa=clr_cnt`, `rf_wd=0`, `core_stall=1`, and ignores core inputs.
  - At `clr_cnt==31`, go to IDLE. CLEAR lasts exactly 31 cycles.
- **IDLE:**
  - `dbg_req_ready=1`. It is 0 in every other state.
  - On accept, latch we/addr/wdata and clear `wait_cnt` (width clog2(MAX_WAIT+1)).
  - Next state is WR if `we`, else RD.
- **WR (opportunistic write):**
  - If `core_write==0`, drive `rf_write=1` with the latched addr/wdata and go to RSP.
  - Else if `wait_cnt==MAX_WAIT`, steal the port: `core_stall=1`, drive the debug write, go to RSP.
  - Else increment `wait_cnt` and keep passthrough.
- **RD:**
  - `core_stall=1`, `rf_ra2=latched addr`, `rf_ra1=core_ra1`, `rf_write=0`.
  - Register `rf_rd2` into `dbg_rsp_rdata`, then go to RSP.
- **RSP:**
  - `dbg_rsp_valid=1` for this cycle only.
  - `dbg_rsp_rdata` holds its value until the next response; it is 0 after a write.
  - Next state is IDLE.
- **Address 0:** a debug write to x0 is issued normally; the regfile discards it. A debug read of x0 returns 0.
- **Responses:** no back-pressure on the response channel; the requester must accept the pulse.
- **Reset:** `rst` in any state aborts the operation. The latched request is discarded and no response is issued. The FSM goes to CLEAR (or IDLE when `CLEAR_ON_RESET=0`).

## Timing
- **Reset values:**
  - state = CLEAR (or IDLE), `clr_cnt=1`, `wait_cnt=0`
  - `dbg_req_ready=0` (1 when `CLEAR_ON_RESET=0`), `dbg_rsp_valid=0`, `dbg_rsp_rdata=0`
  - `core_stall=1` (0 when `CLEAR_ON_RESET=0`)
- **First debug accept:** possible no earlier than cycle 32 after reset deassert.
- **Read:**
  - Accept edge T, RD during T+1 (stall), `dbg_rsp_valid` with data during T+2.
  - Next accept at T+3, so back-to-back requests complete every 3 cycles.
- **Write, idle core:** accept T, write committed at the end of T+1, response during T+2.
- **Write, continuously busy core:** the steal happens in WR cycle MAX_WAIT+1. The response follows one cycle later. Worst case is MAX_WAIT+2 cycles from accept to response.
- **Read after write:** a debug read accepted after a debug write response returns the new value (the regfile commits on the write edge).
- **Combinational paths:** `core_stall` is combinational from state, `wait_cnt` and `core_write`. There is no combinational path from `dbg_req_*` to `rf_*`.

## Test plan
- **Reset clear:**
  - Preload regfile with 0xA5A5A5A5 via core, assert `rst` 1 cycle.
  - Required: 31 cycles of `core_stall=1` and `rf_wa` = 1..31 with `rf_wd=0`.
  - Required: debug reads of x1, x17, x31 return 0.
- **Debug read:**
  - Core writes x5=0x12345678, then debug read x5.
  - Required: one stall cycle, `dbg_rsp_valid` 2 cycles after accept, rdata=0x12345678.
- **Debug write, idle core:**
  - Debug write x9=0xDEADBEEF with `core_write=0`.
  - Required: `rf_write` at accept+1, response at accept+2.
  - Required: a following debug read of x9 returns 0xDEADBEEF.
- **Starvation steal:**
  - Hold `core_write=1` continuously, debug write x3=0xCAFEF00D with `MAX_WAIT=15`.
  - Required: `core_stall` high exactly in WR cycle 16, x3=0xCAFEF00D, core write suppressed that cycle.
- **x0:** debug write x0=0xFFFFFFFF then read x0. Required: response rdata 0.
- **Reset mid-operation:**
  - Assert `rst` while in WR with a pending write x7=0x1.
  - Required: no `dbg_rsp_valid`, x7 not written, CLEAR restarts at `rf_wa=1`.
